elevator_ctrl_fsm: RTL and testbench

Four-floor elevator controller. Latches floor-call bits into a pending-request register and moves the car one floor at a time using SCAN ordering. It opens the door for a fixed dwell at each requested floor and reports floor, door state and travel direction. It sits between the call-button request logic and the status/display logic, and is the top-level control block of the elevator design.

---
 rtl/elevator_pkg.sv | 45 ++++
 rtl/elevator_ctrl_fsm.sv | 129 ++++++++++++
 tb/tb_elevator_ctrl_fsm.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types, encodings and request-scan helpers for the four-floor elevator controller.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = 2;

    localparam logic [FLOOR_W-1:0] BOTTOM_FLOOR = 2'd0;
    localparam logic [FLOOR_W-1:0] TOP_FLOOR    = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    function automatic logic req_above(input logic [NUM_FLOORS-1:0] pend,
                                       input logic [FLOOR_W-1:0]    floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend[i] && (i > int'(floor))) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic req_below(input logic [NUM_FLOORS-1:0] pend,
                                       input logic [FLOOR_W-1:0]    floor);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend[i] && (i < int'(floor))) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] floor);
        return NUM_FLOORS'(1) << floor;
    endfunction

endpackage

// File: rtl/elevator_ctrl_fsm.sv
// SCAN-ordered four-floor elevator controller: latches calls, steps the car one floor
// per TRAVEL_CYCLES, and dwells DOOR_CYCLES at each requested floor.
module elevator_ctrl_fsm
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] floor_request,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  door_open,
    output logic [1:0]            direction
);

    localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

    state_t                  state_q,   state_d;
    logic [FLOOR_W-1:0]      floor_q,   floor_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic                    dir_up_q,  dir_up_d;

    logic [NUM_FLOORS-1:0]   clear_mask;
    logic [FLOOR_W-1:0]      step_floor;
    logic                    any_above;
    logic                    any_below;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            floor_q   <= BOTTOM_FLOOR;
            pending_q <= '0;
            cnt_q     <= '0;
            dir_up_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            dir_up_q  <= dir_up_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        cnt_d      = cnt_q;
        dir_up_d   = dir_up_q;
        clear_mask = '0;
        step_floor = floor_q;
        any_above  = req_above(pending_q, floor_q);
        any_below  = req_below(pending_q, floor_q);

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pending_q[floor_q]) begin
                    state_d    = DOOR_OPEN;
                    clear_mask = floor_mask(floor_q);
                end else if (any_above && (!any_below || dir_up_q)) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (any_below) begin
                    state_d  = MOVE_DOWN;
                    dir_up_d = 1'b0;
                end
            end

            MOVE_UP, MOVE_DOWN: begin
                if (cnt_q == TRAVEL_LAST) begin
                    cnt_d = '0;
                    // Limits are unreachable while a target exists; fall back to IDLE defensively.
                    if ((state_q == MOVE_UP && floor_q == TOP_FLOOR) ||
                        (state_q == MOVE_DOWN && floor_q == BOTTOM_FLOOR)) begin
                        state_d = IDLE;
                    end else begin
                        step_floor = (state_q == MOVE_UP) ? floor_q + 2'd1 : floor_q - 2'd1;
                        floor_d    = step_floor;
                        if (pending_q[step_floor]) begin
                            state_d    = DOOR_OPEN;
                            clear_mask = floor_mask(step_floor);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DOOR_OPEN: begin
                clear_mask = floor_mask(floor_q);
                if (cnt_q == DOOR_LAST) begin
                    cnt_d = '0;
                    if (dir_up_q ? any_above : any_below) begin
                        state_d = dir_up_q ? MOVE_UP : MOVE_DOWN;
                    end else if (dir_up_q ? any_below : any_above) begin
                        state_d  = dir_up_q ? MOVE_DOWN : MOVE_UP;
                        dir_up_d = !dir_up_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase

        // A stop clears its floor even if a fresh call for it lands on the same edge.
        pending_d = (pending_q | floor_request) & ~clear_mask;
    end

    always_comb begin
        unique case (state_q)
            MOVE_UP:   direction = DIR_UP;
            MOVE_DOWN: direction = DIR_DOWN;
            default:   direction = DIR_IDLE;
        endcase
    end

    assign door_open     = (state_q == DOOR_OPEN);
    assign current_floor = floor_q;

endmodule

// File: tb/tb_elevator_ctrl_fsm.sv
// Bench for elevator_ctrl_fsm: constant vector table, corner-case sequences, and
// randomized calls checked every cycle against a timer-based car model.
module tb_elevator_ctrl_fsm;

    localparam int TRAVEL = 8;
    localparam int DOOR   = 4;

    logic       clk;
    logic       rst;
    logic [3:0] floor_request;
    logic [1:0] current_floor;
    logic       door_open;
    logic [1:0] direction;

    int tests;
    int fails;

    elevator_ctrl_fsm #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
        .clk           (clk),
        .rst           (rst),
        .floor_request (floor_request),
        .current_floor (current_floor),
        .door_open     (door_open),
        .direction     (direction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: car as a mode plus countdown timer ----------------
    typedef enum int {M_IDLE, M_TRAVEL, M_DWELL} mode_t;
    mode_t m_mode;
    int    m_floor;
    int    m_dir;
    int    m_pref;
    int    m_timer;
    bit    m_pend[4];

    function automatic bit any_toward(input int d);
        bit hit;
        hit = 0;
        for (int f = 0; f < 4; f++)
            if (m_pend[f] && ((f - m_floor) * d > 0)) hit = 1;
        return hit;
    endfunction

    function automatic void start_travel(input int d);
        m_mode  = M_TRAVEL;
        m_dir   = d;
        m_pref  = d;
        m_timer = TRAVEL;
    endfunction

    function automatic void model_step(input logic [3:0] req, input logic rstv);
        int clr;
        bit up, dn;
        if (!rstv) begin
            m_mode = M_IDLE; m_floor = 0; m_dir = 0; m_pref = 1; m_timer = 0;
            for (int f = 0; f < 4; f++) m_pend[f] = 0;
            return;
        end
        clr = -1;
        case (m_mode)
            M_IDLE: begin
                up = any_toward(1);
                dn = any_toward(-1);
                if (m_pend[m_floor]) begin
                    m_mode = M_DWELL; m_timer = DOOR; clr = m_floor;
                end else if (up || dn) begin
                    start_travel((up && dn) ? m_pref : (up ? 1 : -1));
                end
            end
            M_TRAVEL: begin
                m_timer--;
                if (m_timer == 0) begin
                    m_floor += m_dir;
                    m_timer = TRAVEL;
                    if (m_pend[m_floor]) begin
                        m_mode = M_DWELL; m_timer = DOOR; clr = m_floor;
                    end
                end
            end
            default: begin
                clr = m_floor;
                m_timer--;
                if (m_timer == 0) begin
                    if (any_toward(m_pref))       start_travel(m_pref);
                    else if (any_toward(-m_pref)) start_travel(-m_pref);
                    else                          m_mode = M_IDLE;
                end
            end
        endcase
        for (int f = 0; f < 4; f++) if (req[f]) m_pend[f] = 1;
        if (clr >= 0) m_pend[clr] = 0;
    endfunction

    function automatic logic [4:0] model_out();
        logic [1:0] d;
        d = (m_mode == M_TRAVEL) ? ((m_dir > 0) ? 2'b01 : 2'b10) : 2'b00;
        return {2'(m_floor), (m_mode == M_DWELL), d};
    endfunction

    // ---------------- checking and driving ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [3:0] req, input logic rstv);
        floor_request = req;
        rst           = rstv;
        @(posedge clk);
        model_step(req, rstv);
        #1;
        check("model", 8'({current_floor, door_open, direction}), 8'(model_out()));
    endtask

    task automatic run(input int n, input logic [3:0] req, input logic rstv);
        for (int i = 0; i < n; i++) cyc((i == 0) ? req : 4'b0000, rstv);
    endtask

    function automatic logic [7:0] outs();
        return 8'({current_floor, door_open, direction});
    endfunction

    typedef struct {
        logic       rstv;
        logic [3:0] req;
        int         n;
        logic [1:0] floor;
        logic       door;
        logic [1:0] dir;
    } vec_t;

    vec_t       vecs[17];
    logic [1:0] exp_q[$];

    initial begin
        bit         prev_door;
        int         door_cnt;
        int         reopen;
        bit         moved;
        logic [1:0] exp_f;
        logic [3:0] r;

        tests = 0;
        fails = 0;
        rst = 1'b0;
        floor_request = 4'b0000;

        // Reset, call at current floor, then single up call from floor 0 to floor 3.
        vecs[0]  = '{1'b0, 4'b0000, 2, 2'd0, 1'b0, 2'b00};
        vecs[1]  = '{1'b1, 4'b0001, 1, 2'd0, 1'b0, 2'b00};
        vecs[2]  = '{1'b1, 4'b0000, 1, 2'd0, 1'b1, 2'b00};
        vecs[3]  = '{1'b1, 4'b0000, 3, 2'd0, 1'b1, 2'b00};
        vecs[4]  = '{1'b1, 4'b0000, 1, 2'd0, 1'b0, 2'b00};
        vecs[5]  = '{1'b1, 4'b0000, 3, 2'd0, 1'b0, 2'b00};
        vecs[6]  = '{1'b1, 4'b1000, 1, 2'd0, 1'b0, 2'b00};
        vecs[7]  = '{1'b1, 4'b0000, 1, 2'd0, 1'b0, 2'b01};
        vecs[8]  = '{1'b1, 4'b0000, 7, 2'd0, 1'b0, 2'b01};
        vecs[9]  = '{1'b1, 4'b0000, 1, 2'd1, 1'b0, 2'b01};
        vecs[10] = '{1'b1, 4'b0000, 8, 2'd2, 1'b0, 2'b01};
        vecs[11] = '{1'b1, 4'b0000, 7, 2'd2, 1'b0, 2'b01};
        vecs[12] = '{1'b1, 4'b0000, 1, 2'd3, 1'b1, 2'b00};
        vecs[13] = '{1'b1, 4'b0000, 3, 2'd3, 1'b1, 2'b00};
        vecs[14] = '{1'b1, 4'b0000, 1, 2'd3, 1'b0, 2'b00};
        vecs[15] = '{1'b1, 4'b0000, 4, 2'd3, 1'b0, 2'b00};
        vecs[16] = '{1'b0, 4'b0000, 1, 2'd0, 1'b0, 2'b00};

        for (int v = 0; v < 17; v++) begin
            run(vecs[v].n, vecs[v].req, vecs[v].rstv);
            check($sformatf("vec%0d", v), outs(),
                  8'({vecs[v].floor, vecs[v].door, vecs[v].dir}));
        end

        // SCAN: passing floor 1 on the way to 3, calls for 2 and 0 -> stops 2, 3, 0.
        run(2, 4'b0000, 1'b0);
        run(13, 4'b1000, 1'b1);
        check("scan_pos", outs(), 8'({2'd1, 1'b0, 2'b01}));
        exp_q = {2'd2, 2'd3, 2'd0};
        prev_door = 1'b0;
        cyc(4'b0101, 1'b1);
        for (int i = 0; i < 60; i++) begin
            cyc(4'b0000, 1'b1);
            if (door_open && !prev_door) begin
                if (exp_q.size() == 0) begin
                    check("scan_extra_stop", 8'(current_floor), 8'hff);
                end else begin
                    exp_f = exp_q.pop_front();
                    check("scan_stop", 8'(current_floor), 8'(exp_f));
                end
            end
            prev_door = door_open;
        end
        check("scan_left", 8'(exp_q.size()), 8'd0);
        check("scan_final", outs(), 8'({2'd0, 1'b0, 2'b00}));

        // Absorbed call: repeat floor-2 call while its door is open.
        run(2, 4'b0000, 1'b0);
        run(18, 4'b0100, 1'b1);
        check("absorb_open", outs(), 8'({2'd2, 1'b1, 2'b00}));
        door_cnt = 1;
        reopen = 0;
        prev_door = 1'b1;
        for (int i = 0; i < 24; i++) begin
            cyc((i < 2) ? 4'b0100 : 4'b0000, 1'b1);
            if (door_open) door_cnt++;
            if (door_open && !prev_door) reopen++;
            prev_door = door_open;
        end
        check("absorb_dwell", 8'(door_cnt), 8'(DOOR));
        check("absorb_reopen", 8'(reopen), 8'd0);
        check("absorb_final", outs(), 8'({2'd2, 1'b0, 2'b00}));

        // Reset between floors 1 and 2 while heading to 3.
        run(2, 4'b0000, 1'b0);
        run(13, 4'b1000, 1'b1);
        check("rstmid_pre", outs(), 8'({2'd1, 1'b0, 2'b01}));
        cyc(4'b0000, 1'b0);
        check("rstmid_abort", outs(), 8'({2'd0, 1'b0, 2'b00}));
        moved = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc(4'b0000, 1'b1);
            if (current_floor != 2'd0 || direction != 2'b00 || door_open) moved = 1'b1;
        end
        check("rstmid_still", 8'(moved), 8'd0);

        // Random calls with rare resets, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            cyc(r, ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
